// File: rtl/sr_bank_arbiter.sv
// Round-robin arbiter sequencing A/B set/clear masks onto a shared SR flop bank.
// Latency: s/r drive starts the clock after the handshake; HOLD_CYC drive clocks and then 1 release clock.
// Backpressure: one ready at most, only in IDLE; optional SR_CLR_PRIORITY_EN makes conflict bits clear.
module sr_bank_arbiter #(
  parameter int WIDTH    = 8,
  parameter int HOLD_CYC = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] a_set,
  input  logic [WIDTH-1:0] a_clr,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [WIDTH-1:0] b_set,
  input  logic [WIDTH-1:0] b_clr,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             grant_b,
  output logic             err_conflict
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYC - 1);

  state_t           state;
  logic [3:0]       hold_cnt;
  logic             rr_b;
  logic             idle;
  logic             accept;
  logic             sel_b;
  logic [WIDTH-1:0] sel_set;
  logic [WIDTH-1:0] sel_clr;
  logic [WIDTH-1:0] next_s;
  logic [WIDTH-1:0] next_r;

  // rr_b breaks the tie only when both requesters are valid together
  assign idle    = (state == IDLE);
  assign a_ready = idle & a_valid & (~b_valid | ~rr_b);
  assign b_ready = idle & b_valid & (~a_valid | rr_b);
  assign accept  = a_ready | b_ready;
  assign sel_b   = b_ready;
  assign sel_set = sel_b ? b_set : a_set;
  assign sel_clr = sel_b ? b_clr : a_clr;

`ifdef SR_CLR_PRIORITY_EN
  assign next_s = sel_set & ~sel_clr;
  assign next_r = sel_clr;
`else
  assign next_s = sel_set & ~sel_clr;
  assign next_r = sel_clr & ~sel_set;
`endif

  assign busy = ~idle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      hold_cnt     <= '0;
      rr_b         <= 1'b0;
      s            <= '0;
      r            <= '0;
      grant_b      <= 1'b0;
      err_conflict <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state    <= DRIVE;
            s        <= next_s;
            r        <= next_r;
            grant_b  <= sel_b;
            rr_b     <= ~sel_b;
            hold_cnt <= HOLD_LAST;
            if (|(sel_set & sel_clr)) err_conflict <= 1'b1;
          end
        end
        DRIVE: begin
          if (hold_cnt == 4'd0) begin
            state <= RELEASE;
            s     <= '0;
            r     <= '0;
          end else begin
            hold_cnt <= hold_cnt - 4'd1;
          end
        end
        RELEASE: state <= IDLE;
        default: begin
          state <= IDLE;
          s     <= '0;
          r     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_bank_arbiter.sv
// Directed bench for sr_bank_arbiter: cycle table on a HOLD_CYC=1 instance plus
// hand sequences for a HOLD_CYC=3 instance and asynchronous reset mid-drive.
module tb_sr_bank_arbiter;

  logic       clk;
  logic       rst_n;
  logic       a_valid, b_valid, a_ready, b_ready, busy, grant_b, err_conflict;
  logic [7:0] a_set, a_clr, b_set, b_clr, s, r;
  logic       a2_valid, b2_valid, a2_ready, b2_ready, busy2, grant_b2, err2;
  logic [7:0] a2_set, a2_clr, b2_set, b2_clr, s2, r2;

  int tests_run = 0;
  int tests_failed = 0;

  sr_bank_arbiter #(.WIDTH(8), .HOLD_CYC(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_set(a_set), .a_clr(a_clr),
    .b_valid(b_valid), .b_ready(b_ready), .b_set(b_set), .b_clr(b_clr),
    .s(s), .r(r), .busy(busy), .grant_b(grant_b), .err_conflict(err_conflict)
  );

  sr_bank_arbiter #(.WIDTH(8), .HOLD_CYC(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a2_valid), .a_ready(a2_ready), .a_set(a2_set), .a_clr(a2_clr),
    .b_valid(b2_valid), .b_ready(b2_ready), .b_set(b2_set), .b_clr(b2_clr),
    .s(s2), .r(r2), .busy(busy2), .grant_b(grant_b2), .err_conflict(err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SR_CLR_PRIORITY_EN
  localparam logic [7:0] CONF_R = 8'h01;
`else
  localparam logic [7:0] CONF_R = 8'h00;
`endif

  typedef struct {
    logic       av;
    logic [7:0] as;
    logic [7:0] ac;
    logic       bv;
    logic [7:0] bs;
    logic [7:0] bc;
    logic       ear;
    logic       ebr;
    logic [7:0] es;
    logic [7:0] er;
    logic       ebusy;
    logic       eg;
    logic       eerr;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Invariants on both instances, every cycle
  always @(negedge clk) begin
    #2;
    chk("s_and_r_zero", 32'(s & r), 32'h0);
    chk("one_ready", 32'(a_ready & b_ready), 32'h0);
    chk("s_and_r_zero_h3", 32'(s2 & r2), 32'h0);
    chk("one_ready_h3", 32'(a2_ready & b2_ready), 32'h0);
  end

  initial begin
    // av  as     ac     bv  bs     bc     ar  br  s      r       busy g  err
    vecs[0]  = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 8'h0F, 8'hF0, 1'b1, 8'h81, 8'h01, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 8'h3C, 8'h00, 1'b1, 8'h81, 8'h01, 1'b0, 1'b0, 8'h0F, 8'hF0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 8'h3C, 8'h00, 1'b1, 8'h81, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 8'h3C, 8'h00, 1'b1, 8'h81, 8'h01, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 8'h3C, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h80, CONF_R, 1'b1, 1'b1, 1'b1};
    vecs[6]  = '{1'b1, 8'h3C, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, 8'h3C, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h3C, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1};
    vecs[12] = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1};
    vecs[13] = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1};

    rst_n = 1'b0;
    {a_valid, b_valid, a2_valid, b2_valid} = '0;
    {a_set, a_clr, b_set, b_clr} = '0;
    {a2_set, a2_clr, b2_set, b2_clr} = '0;

    // Reset values before any clock edge
    #3;
    chk("rst_s", 32'(s), 32'h0);
    chk("rst_r", 32'(r), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_grant_b", 32'(grant_b), 32'h0);
    chk("rst_err", 32'(err_conflict), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      a_valid = vecs[i].av; a_set = vecs[i].as; a_clr = vecs[i].ac;
      b_valid = vecs[i].bv; b_set = vecs[i].bs; b_clr = vecs[i].bc;
      #1;
      chk($sformatf("v%0d_a_ready", i), 32'(a_ready), 32'(vecs[i].ear));
      chk($sformatf("v%0d_b_ready", i), 32'(b_ready), 32'(vecs[i].ebr));
      chk($sformatf("v%0d_s", i), 32'(s), 32'(vecs[i].es));
      chk($sformatf("v%0d_r", i), 32'(r), 32'(vecs[i].er));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].ebusy));
      chk($sformatf("v%0d_grant_b", i), 32'(grant_b), 32'(vecs[i].eg));
      chk($sformatf("v%0d_err", i), 32'(err_conflict), 32'(vecs[i].eerr));
    end

    // HOLD_CYC=3: s held exactly 3 clocks, then one release clock
    @(negedge clk);
    a2_valid = 1'b1; a2_set = 8'hFF; a2_clr = 8'h00;
    #1 chk("h3_a_ready", 32'(a2_ready), 32'h1);
    @(negedge clk);
    a2_valid = 1'b0; a2_set = 8'h00;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("h3_drive%0d_s", k), 32'(s2), 32'hFF);
      chk($sformatf("h3_drive%0d_busy", k), 32'(busy2), 32'h1);
      @(negedge clk);
    end
    #1;
    chk("h3_release_s", 32'(s2), 32'h0);
    chk("h3_release_busy", 32'(busy2), 32'h1);
    @(negedge clk);
    #1;
    chk("h3_idle_busy", 32'(busy2), 32'h0);

    // Asynchronous reset in the middle of DRIVE
    @(negedge clk);
    a_valid = 1'b1; a_set = 8'h55; a_clr = 8'h00;
    b_valid = 1'b1; b_set = 8'h11; b_clr = 8'h00;
    #1 chk("mid_a_ready", 32'(a_ready), 32'h1);
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
    #1 chk("mid_drive_s", 32'(s), 32'h55);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_s", 32'(s), 32'h0);
    chk("arst_r", 32'(r), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_err", 32'(err_conflict), 32'h0);
    chk("arst_grant_b", 32'(grant_b), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    a_valid = 1'b1; a_set = 8'h12; a_clr = 8'h00;
    b_valid = 1'b1;
    #1;
    chk("post_rst_a_ready", 32'(a_ready), 32'h1);
    chk("post_rst_b_ready", 32'(b_ready), 32'h0);
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
    #1;
    chk("post_rst_s", 32'(s), 32'h12);
    chk("post_rst_busy", 32'(busy), 32'h1);
    @(negedge clk);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
